sha256_core_ctrl: RTL

- Sequencing controller for the SHA-256 compression datapath. It accepts 512-bit message blocks over a valid/ready handshake and generates the load enables that drive the block-capture, working-variable and hash-state registers.
- It issues the round index for 64 rounds, triggers the final hash accumulate, and presents digest-valid with backpressure.
- It sits between the message padder (upstream) and the hash-state/working-variable register bank (downstream).

---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_round_cnt.sv | 27 ++
 rtl/sha256_core_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 controller states, round constants and IV
package sha256_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int MSG_WORDS  = 16;
  localparam int ROUND_W    = $clog2(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Initial hash value H0..H7, also consumed by the datapath's IV mux.
  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] iv_word(input int unsigned i);
    return IV[i[2:0]];
  endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - round index counter with enable, clear and terminal count
module sha256_round_cnt #(
  parameter int N = 64,
  parameter int W = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(N - 1));

  // Wraps to zero on terminal count so the next block starts at round 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr || (en && tc)) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sha256_core_ctrl.sv
// rtl/sha256_core_ctrl.sv - SHA-256 compression sequencing controller
module sha256_core_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int MSG_WORDS  = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          blk_valid,
  input  logic                          blk_first,
  input  logic                          blk_last,
  output logic                          blk_ready,
  output logic                          ld_msg,
  output logic                          ld_work,
  output logic                          work_src_iv,
  output logic                          ld_hash,
  output logic                          hash_src_iv,
  output logic                          round_en,
  output logic [$clog2(NUM_ROUNDS)-1:0] round_idx,
  output logic                          w_src_msg,
  output logic                          digest_valid,
  input  logic                          digest_ready,
  output logic                          busy,
  output logic [CNT_W-1:0]              blk_count
);
  import sha256_pkg::*;

  localparam int RW = $clog2(NUM_ROUNDS);

  state_t state;
  logic   first_q;
  logic   last_q;
  logic   round_tc;

  sha256_round_cnt #(.N(NUM_ROUNDS), .W(RW)) u_round_cnt (
    .CLK (CLK),
    .RST (RST),
    .en  (state == ROUND),
    .clr (state != ROUND),
    .cnt (round_idx),
    .tc  (round_tc)
  );

  assign blk_ready = (state == IDLE);

  // Strobes are registered against the state being entered, so each one
  // is high for exactly the cycles the FSM spends in the matching state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      blk_count    <= '0;
      ld_msg       <= 1'b0;
      ld_work      <= 1'b0;
      work_src_iv  <= 1'b0;
      ld_hash      <= 1'b0;
      hash_src_iv  <= 1'b0;
      round_en     <= 1'b0;
      w_src_msg    <= 1'b0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid && blk_ready) begin
            first_q     <= blk_first;
            last_q      <= blk_last;
            ld_msg      <= 1'b1;
            ld_work     <= 1'b1;
            work_src_iv <= blk_first;
            ld_hash     <= blk_first;
            hash_src_iv <= blk_first;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          ld_msg      <= 1'b0;
          ld_work     <= 1'b0;
          work_src_iv <= 1'b0;
          ld_hash     <= 1'b0;
          hash_src_iv <= 1'b0;
          if (first_q) begin
            blk_count <= '0;
          end
          round_en  <= 1'b1;
          w_src_msg <= (MSG_WORDS > 0);
          state     <= ROUND;
        end
        ROUND: begin
          // Looks one round ahead: this value is seen during round_idx+1.
          w_src_msg <= (int'(round_idx) < MSG_WORDS - 1);
          if (round_tc) begin
            round_en  <= 1'b0;
            w_src_msg <= 1'b0;
            ld_hash   <= 1'b1;
            state     <= FINAL;
          end
        end
        FINAL: begin
          ld_hash <= 1'b0;
          if (blk_count != {CNT_W{1'b1}}) begin
            blk_count <= blk_count + CNT_W'(1);
          end
          if (last_q) begin
            digest_valid <= 1'b1;
            state        <= DONE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
